// File: rtl/gfx_arb_pkg.sv
// ---------------------------------------------------------------------------
// gfx_arb_pkg
// Shared definitions for graphics_cmd_arbiter and its command FIFO:
//   - register offsets decoded from Address[3:2]
//   - bit positions inside the status word
//   - bus-side and dispatch-side FSM state types
// Optional feature macro: GFX_ARB_DROP_EN (when defined, a push into a full
// FIFO is acknowledged and dropped, so the bus FSM has no wait-for-space state).
// ---------------------------------------------------------------------------
package gfx_arb_pkg;

  // Register offsets (Address[3:2])
  localparam logic [1:0] GFX_CMD    = 2'd0;
  localparam logic [1:0] GFX_STATUS = 2'd1;
  localparam logic [1:0] GFX_FLUSH  = 2'd2;

  // Status word bit positions
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 15;

`ifdef GFX_ARB_DROP_EN
  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_ACK  = 2'd2
  } bus_state_t;
`else
  typedef enum logic [1:0] {
    B_IDLE       = 2'd0,
    B_WAIT_SPACE = 2'd1,
    B_ACK        = 2'd2
  } bus_state_t;
`endif

  typedef enum logic [1:0] {
    D_IDLE      = 2'd0,
    D_WAIT_LOW  = 2'd1,
    D_WAIT_HIGH = 2'd2
  } disp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock command FIFO with flush. Head data is combinational so the
// consumer can register it in the same cycle it pops.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write wdata_i (ignored while full or flushing)
//   pop_i         drop the head entry (ignored while empty)
//   flush_i       empty the FIFO; wins over a same-cycle push/pop
//   wdata_i       data to push
//   head_o        current head entry (combinational)
//   count_o       number of stored entries (registered)
//   full_o        count == DEPTH
//   empty_o       count == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push is refused while full even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/graphics_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// graphics_cmd_arbiter
// Buffers CPU command writes in a FIFO and feeds them one at a time to the
// pixel engine (vga_control) using a start strobe and its ready handshake.
// Optional feature macro: GFX_ARB_DROP_EN
//   undefined: push into a full FIFO holds off DTAck until space appears
//   defined  : push into a full FIFO is acked, dropped, and sets sticky
//              status bit3 (cleared by flush or reset)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   AS_L_i, WE_L_i      CPU address strobe / write enable (active low)
//   Graphics_Select_i   decoder select for this block
//   Address_i           CPU address; only [3:2] decoded
//   Data_In_i           CPU write data (command word)
//   Data_Out_o          status read data, 0 unless acking a status read
//   DTAck_o             transfer acknowledge
//   vga_ready_i         pixel engine idle
//   vga_start_o         one-cycle command strobe
//   vga_data_o          command word, held until the next dispatch
// ---------------------------------------------------------------------------
module graphics_cmd_arbiter
  import gfx_arb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AS_L_i,
  input  logic              WE_L_i,
  input  logic              Graphics_Select_i,
  input  logic [31:0]       Address_i,
  input  logic [DATA_W-1:0] Data_In_i,
  output logic [31:0]       Data_Out_o,
  output logic              DTAck_o,
  input  logic              vga_ready_i,
  output logic              vga_start_o,
  output logic [DATA_W-1:0] vga_data_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_t        bus_q, bus_d;
  disp_state_t       disp_q, disp_d;
  logic [31:0]       data_q, data_d;
  logic              wait_cnt_q, wait_cnt_d;
  logic              vga_start_q, vga_start_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
`ifdef GFX_ARB_DROP_EN
  logic              ovf_q, ovf_d;
`endif

  logic              fifo_push, fifo_pop, fifo_flush;
  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  logic              access;
  logic [31:0]       status;
  logic              unused_addr;

  assign unused_addr = ^{Address_i[31:4], Address_i[1:0]};

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (Data_In_i),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign access = !AS_L_i && Graphics_Select_i;

  // Live status; it is captured into data_q on the access edge.
  always_comb begin
    status                        = '0;
    status[ST_EMPTY]              = fifo_empty;
    status[ST_FULL]               = fifo_full;
    status[ST_BUSY]               = (disp_q != D_IDLE) || !vga_ready_i;
`ifdef GFX_ARB_DROP_EN
    status[ST_OVF]                = ovf_q;
`endif
    status[ST_CNT_MSB:ST_CNT_LSB] = 8'(fifo_count);
  end

  // Bus FSM: one action per strobe; the B_ACK state absorbs a long AS_L.
  always_comb begin
    bus_d      = bus_q;
    data_d     = data_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
`ifdef GFX_ARB_DROP_EN
    ovf_d      = ovf_q;
`endif
    unique case (bus_q)
      B_IDLE: begin
        if (access) begin
          bus_d  = B_ACK;
          data_d = '0;
          unique case (Address_i[3:2])
            GFX_CMD: begin
              if (!WE_L_i) begin
                if (fifo_full) begin
`ifdef GFX_ARB_DROP_EN
                  ovf_d = 1'b1;
`else
                  bus_d = B_WAIT_SPACE;
`endif
                end else begin
                  fifo_push = 1'b1;
                end
              end
            end
            GFX_STATUS: begin
              if (WE_L_i) data_d = status;
            end
            GFX_FLUSH: begin
              if (!WE_L_i) begin
                fifo_flush = 1'b1;
`ifdef GFX_ARB_DROP_EN
                ovf_d      = 1'b0;
`endif
              end
            end
            default: ;
          endcase
        end
      end
`ifndef GFX_ARB_DROP_EN
      B_WAIT_SPACE: begin
        // A strobe released before space appears abandons the write.
        if (AS_L_i) begin
          bus_d = B_IDLE;
        end else if (!fifo_full) begin
          fifo_push = 1'b1;
          bus_d     = B_ACK;
        end
      end
`endif
      B_ACK: begin
        if (AS_L_i) bus_d = B_IDLE;
      end
      default: bus_d = B_IDLE;
    endcase
  end

  // Dispatch FSM: pop into vga_data when the engine is idle, then follow
  // its ready low/high cycle. An engine that never drops ready within two
  // cycles is taken to have finished already.
  always_comb begin
    disp_d      = disp_q;
    wait_cnt_d  = wait_cnt_q;
    vga_data_d  = vga_data_q;
    vga_start_d = 1'b0;
    fifo_pop    = 1'b0;
    unique case (disp_q)
      D_IDLE: begin
        if (!fifo_empty && vga_ready_i) begin
          fifo_pop    = 1'b1;
          vga_data_d  = fifo_head;
          vga_start_d = 1'b1;
          wait_cnt_d  = 1'b0;
          disp_d      = D_WAIT_LOW;
        end
      end
      D_WAIT_LOW: begin
        if (!vga_ready_i) begin
          disp_d = D_WAIT_HIGH;
        end else if (wait_cnt_q) begin
          disp_d = D_IDLE;
        end else begin
          wait_cnt_d = 1'b1;
        end
      end
      D_WAIT_HIGH: begin
        if (vga_ready_i) disp_d = D_IDLE;
      end
      default: disp_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q       <= B_IDLE;
      disp_q      <= D_IDLE;
      data_q      <= '0;
      wait_cnt_q  <= 1'b0;
      vga_start_q <= 1'b0;
      vga_data_q  <= '0;
`ifdef GFX_ARB_DROP_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      bus_q       <= bus_d;
      disp_q      <= disp_d;
      data_q      <= data_d;
      wait_cnt_q  <= wait_cnt_d;
      vga_start_q <= vga_start_d;
      vga_data_q  <= vga_data_d;
`ifdef GFX_ARB_DROP_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign DTAck_o     = (bus_q == B_ACK);
  assign Data_Out_o  = (bus_q == B_ACK) ? data_q : 32'd0;
  assign vga_start_o = vga_start_q;
  assign vga_data_o  = vga_data_q;

endmodule

// File: tb/tb_graphics_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_graphics_cmd_arbiter
// Self-checking bench for graphics_cmd_arbiter (DEPTH=8, DATA_W=32).
// Reference model: a queue of accepted command words. Every acknowledged
// command write appends to it, a flush empties it, and every vga_start must
// present the oldest word. Status expectations come from the queue size.
// Honours GFX_ARB_DROP_EN when defined for the full-FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_graphics_cmd_arbiter;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        AS_L, WE_L, Graphics_Select;
  logic [31:0] Address, Data_In, Data_Out, vga_data;
  logic        DTAck, vga_ready, vga_start;

  always #5 clk = ~clk;

  graphics_cmd_arbiter #(
    .DEPTH  (DEPTH),
    .DATA_W (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .AS_L_i            (AS_L),
    .WE_L_i            (WE_L),
    .Graphics_Select_i (Graphics_Select),
    .Address_i         (Address),
    .Data_In_i         (Data_In),
    .Data_Out_o        (Data_Out),
    .DTAck_o           (DTAck),
    .vga_ready_i       (vga_ready),
    .vga_start_o       (vga_start),
    .vga_data_o        (vga_data)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_q[$];
  bit          model_ovf = 1'b0;
  int          start_cnt = 0;
  time         last_start_time = 0;
  time         last_ack_time = 0;
  logic [31:0] last_start_data = '0;
  int          last_lat = 0;
  bit          vga_auto = 1'b0;
  int          busy_len = 4;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    logic [31:0] s;
    s        = '0;
    s[0]     = (model_q.size() == 0);
    s[1]     = (model_q.size() == DEPTH);
    s[2]     = busy;
    s[3]     = model_ovf;
    s[15:8]  = 8'(model_q.size());
    return s;
  endfunction

  task automatic model_push(input logic [31:0] d);
    if (model_q.size() >= DEPTH) model_ovf = 1'b1;
    else model_q.push_back(d);
  endtask

  // One CPU bus cycle. AS_L stays low for the ack latency plus 'hold' cycles.
  task automatic bus_access(input logic [1:0] off, input bit wr, input logic [31:0] d,
                            input int hold, input int max_wait,
                            output bit acked, output logic [31:0] rd);
    acked = 1'b0;
    rd    = '0;
    @(negedge clk);
    Address = {28'h0, off, 2'b00};
    Data_In = d;
    WE_L = !wr;
    Graphics_Select = 1'b1;
    AS_L = 1'b0;
    for (int i = 1; i <= max_wait; i++) begin
      @(negedge clk);
      if (DTAck) begin
        acked = 1'b1;
        last_lat = i;
        last_ack_time = $time;
        break;
      end
    end
    if (acked) begin
      rd = Data_Out;
      if (wr && off == 2'd0) model_push(d);
      if (wr && off == 2'd2) begin
        model_q.delete();
        model_ovf = 1'b0;
      end
    end
    repeat (hold) @(negedge clk);
    AS_L = 1'b1;
    WE_L = 1'b1;
    Graphics_Select = 1'b0;
    @(negedge clk);
    check_val("ack_release", {31'b0, DTAck}, 32'd0);
  endtask

  // Dispatch monitor: every start must carry the oldest queued word.
  initial forever begin
    @(negedge clk);
    if (!rst && vga_start) begin
      start_cnt++;
      last_start_time = $time;
      last_start_data = vga_data;
      check_val("dispatch_has_pending", {31'b0, model_q.size() != 0}, 32'd1);
      if (model_q.size() != 0) check_val("dispatch_order", vga_data, model_q.pop_front());
    end
  end

  // Pixel engine model: goes busy for busy_len cycles after each start.
  initial forever begin
    @(negedge clk);
    if (vga_auto && !rst && vga_start) begin
      vga_ready = 1'b0;
      repeat (busy_len) @(negedge clk);
      vga_ready = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acked;
    logic [31:0] rd;
    int          s0;

    rst = 1'b1; AS_L = 1'b1; WE_L = 1'b1; Graphics_Select = 1'b0;
    Address = '0; Data_In = '0; vga_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_dtack", {31'b0, DTAck}, 32'd0);
    check_val("rst_start", {31'b0, vga_start}, 32'd0);
    check_val("rst_vga_data", vga_data, 32'd0);
    check_val("rst_data_out", Data_Out, 32'd0);
    rst = 1'b0;

    // Single write, strobe held for 5 cycles
    s0 = start_cnt;
    bus_access(2'd0, 1'b1, 32'h00A5_1234, 4, 20, acked, rd);
    check_val("single_ack", {31'b0, acked}, 32'd1);
    check_val("single_ack_latency", 32'(last_lat), 32'd1);
    repeat (6) @(negedge clk);
    check_val("single_one_start", 32'(start_cnt - s0), 32'd1);
    check_val("single_start_after_ack", 32'(last_start_time - last_ack_time), 32'd10);
    check_val("single_vga_data", last_start_data, 32'h00A5_1234);

    // Reset while the dispatcher waits for ready to return
    vga_auto = 1'b1; busy_len = 6;
    s0 = start_cnt;
    bus_access(2'd0, 1'b1, $urandom, 0, 20, acked, rd);
    check_val("rmid_ack", {31'b0, acked}, 32'd1);
    check_val("rmid_started", 32'(start_cnt - s0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    check_val("rmid_dtack", {31'b0, DTAck}, 32'd0);
    check_val("rmid_start", {31'b0, vga_start}, 32'd0);
    check_val("rmid_vga_data", vga_data, 32'd0);
    check_val("rmid_data_out", Data_Out, 32'd0);
    rst = 1'b0;
    vga_auto = 1'b0;
    repeat (10) @(negedge clk);
    vga_ready = 1'b1;
    bus_access(2'd1, 1'b0, 32'd0, 0, 20, acked, rd);
    check_val("rmid_status", rd, 32'h0000_0001);

    // Fill with the engine held busy
    vga_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_access(2'd0, 1'b1, $urandom, $urandom_range(0, 2), 20, acked, rd);
      check_val("fill_ack", {31'b0, acked}, 32'd1);
    end
    bus_access(2'd1, 1'b0, 32'd0, 0, 20, acked, rd);
    check_val("status_3", rd, 32'h0000_0304);
    check_val("status_3_model", rd, exp_status(1'b1));
    for (int i = 0; i < 5; i++) begin
      bus_access(2'd0, 1'b1, $urandom, 0, 20, acked, rd);
      check_val("fill_ack", {31'b0, acked}, 32'd1);
    end
    bus_access(2'd1, 1'b0, 32'd0, 0, 20, acked, rd);
    check_val("status_full", rd, 32'h0000_0806);
    bus_access(2'd0, 1'b1, 32'hBAD0_0009, 0, 6, acked, rd);
`ifdef GFX_ARB_DROP_EN
    check_val("ninth_acked", {31'b0, acked}, 32'd1);
    bus_access(2'd1, 1'b0, 32'd0, 0, 20, acked, rd);
    check_val("status_ovf", rd, 32'h0000_080E);
`else
    check_val("ninth_stalled", {31'b0, acked}, 32'd0);
    bus_access(2'd1, 1'b0, 32'd0, 0, 20, acked, rd);
    check_val("status_after_abandon", rd, 32'h0000_0806);
`endif
    check_val("status_full_model", rd, exp_status(1'b1));

    // Flush, then release the engine: nothing may be dispatched
    bus_access(2'd2, 1'b1, 32'hFFFF_FFFF, 0, 20, acked, rd);
    check_val("flush_ack", {31'b0, acked}, 32'd1);
    bus_access(2'd1, 1'b0, 32'd0, 0, 20, acked, rd);
    check_val("status_flushed_busy", rd, 32'h0000_0005);
    s0 = start_cnt;
    vga_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_val("flush_no_start", 32'(start_cnt - s0), 32'd0);
    bus_access(2'd1, 1'b0, 32'd0, 0, 20, acked, rd);
    check_val("status_flushed_idle", rd, 32'h0000_0001);

    // Unused offset: acked, reads 0, no push
    bus_access(2'd3, 1'b0, 32'd0, 1, 20, acked, rd);
    check_val("off3_read", rd, 32'd0);

    // 20 random pushes against an engine with 4-cycle busy periods
    vga_auto = 1'b1; busy_len = 4;
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      bus_access(2'd0, 1'b1, $urandom, $urandom_range(0, 3), 300, acked, rd);
      check_val("rand_ack", {31'b0, acked}, 32'd1);
`ifdef GFX_ARB_DROP_EN
      repeat (8 + $urandom_range(0, 4)) @(negedge clk);
`else
      repeat ($urandom_range(0, 4)) @(negedge clk);
`endif
    end
    for (int i = 0; i < 3000 && model_q.size() != 0; i++) @(negedge clk);
    check_val("rand_drained", 32'(model_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    check_val("rand_start_count", 32'(start_cnt - s0), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
